// File: rtl/fpu_pkg.sv
// Shared types and fixed-point widths for the fdiv reciprocal path.
package fpu_pkg;

    localparam int MANT_W        = 24;    // d = 1.m in Q1.23
    localparam int R_W           = 28;    // reciprocal in Q1.27
    localparam int FRAC_W        = 23;    // IEEE single fraction field
    localparam int SEED_BITS_DEF = 8;

    localparam logic [FRAC_W-1:0] R_SAT = 23'h7FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MA,
        MB,
        FIN,
        OUT
    } fsm_state_t;

endpackage

// File: rtl/fdiv_recip_seq_if.sv
// Valid/ready handshake carrying the divisor in and the reciprocal word out.
interface fdiv_recip_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y
    );

endinterface

// File: rtl/finv_seed_rom.sv
// Reciprocal seed table: entry i holds 1/(midpoint of segment i) in Q1.27,
// truncated to 12 significant bits. Contents are fixed at elaboration.
module finv_seed_rom
    import fpu_pkg::*;
#(
    parameter int SEED_BITS = SEED_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SEED_BITS-1:0] addr,
    output logic [R_W-1:0]       q
);

    localparam int DEPTH = 1 << SEED_BITS;

    // 2^(R_W+SEED_BITS) / (2*DEPTH + 2i + 1) is 1/(1 + (i+0.5)/DEPTH) scaled to Q1.27.
    function automatic logic [R_W-1:0] seed_val(input int i);
        logic [63:0] num;
        logic [63:0] quo;
        num = 64'd1 << (R_W + SEED_BITS);
        quo = num / 64'(2 * DEPTH + 2 * i + 1);
        return {1'b0, quo[R_W-2 -: 12], {(R_W-13){1'b0}}};
    endfunction

    logic [R_W-1:0] table_w [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [R_W-1:0] VAL = seed_val(i);
        assign table_w[i] = VAL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= table_w[addr];
        end
    end

endmodule

// File: rtl/fdiv_recip_seq.sv
// Divisor-side reciprocal: seed ROM plus ITERS Newton-Raphson steps on one
// shared 28x28 multiplier, producing {s, e, r} with 1.r = 2/(1.m).
module fdiv_recip_seq
    import fpu_pkg::*;
#(
    parameter int ITERS     = 2,
    parameter int SEED_BITS = SEED_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fdiv_recip_seq_if.slave   bus
);

    localparam int IT_W = $clog2(ITERS) + 1;
    localparam int DROP = R_W - 1 - FRAC_W;   // fraction bits of 2r below the result lsb

    fsm_state_t state, state_nxt;

    logic              s_q;
    logic [7:0]        e_q;
    logic [MANT_W-1:0] d_q;
    logic [R_W-1:0]    r_q;
    logic [R_W-1:0]    t_q;
    logic [IT_W-1:0]   it_q;
    logic [31:0]       y_q;

    logic              accept;
    logic [R_W-1:0]    seed;
    logic [R_W-1:0]    mul_a;
    logic [R_W-1:0]    mul_b;
    logic [2*R_W-1:0]  prod;
    logic [R_W:0]      two_minus_t;
    logic [R_W:0]      two_r_rnd;
    logic [R_W-DROP:0] r_rnd;
    logic [FRAC_W-1:0] r_field;
    logic              unused_bits;

    assign accept = (state == IDLE) && bus.in_valid;

    finv_seed_rom #(.SEED_BITS(SEED_BITS)) u_seed_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .addr (bus.x[FRAC_W-1 -: SEED_BITS]),
        .q    (seed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = SEED;
            end
            SEED:    state_nxt = MA;
            MA:      state_nxt = MB;
            MB:      state_nxt = (int'(it_q) + 1 < ITERS) ? MA : FIN;
            FIN:     state_nxt = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared multiplier: MA forms t = d*r, MB forms r*(2-t); both keep Q1.27.
    assign two_minus_t = {1'b1, {R_W{1'b0}}} - {1'b0, t_q};

    always_comb begin
        mul_a = {d_q, {(R_W-MANT_W){1'b0}}};
        mul_b = r_q;
        if (state == MB) begin
            mul_a = r_q;
            mul_b = two_minus_t[R_W-1:0];
        end
    end

    assign prod = mul_a * mul_b;

    // 2r rounded to nearest at FRAC_W fraction bits; r_rnd is Q2.23.
    assign two_r_rnd = {r_q, 1'b0} + ((R_W+1)'(1) << (DROP - 1));
    assign r_rnd     = two_r_rnd[R_W:DROP];

    always_comb begin
        if (d_q[FRAC_W-1:0] == '0 || r_rnd[R_W-DROP]) begin
            r_field = R_SAT;
        end else if (!r_rnd[R_W-DROP-1]) begin
            // Truncation can leave r a hair under 0.5 when 1.m is just below 2.
            r_field = '0;
        end else begin
            r_field = r_rnd[FRAC_W-1:0];
        end
        if (e_q == 8'h00 || e_q == 8'hFF) r_field = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= 1'b0;
            e_q  <= '0;
            d_q  <= '0;
            r_q  <= '0;
            t_q  <= '0;
            it_q <= '0;
            y_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    s_q <= bus.x[31];
                    e_q <= bus.x[30:23];
                    d_q <= {1'b1, bus.x[FRAC_W-1:0]};
                end
                SEED: begin
                    r_q  <= seed;
                    it_q <= '0;
                end
                MA:  t_q <= prod[2*R_W-2:R_W-1];
                MB: begin
                    r_q  <= prod[2*R_W-2:R_W-1];
                    it_q <= it_q + 1'b1;
                end
                FIN: y_q <= {s_q, e_q, r_field};
                default: ;
            endcase
        end
    end

    assign bus.y = y_q;

    assign unused_bits = ^{prod[2*R_W-1], prod[R_W-2:0], two_minus_t[R_W],
                           two_r_rnd[DROP-1:0]};

endmodule

// File: tb/tb_fdiv_recip_seq.sv
// Randomized self-checking bench for fdiv_recip_seq against an exact 2/d model.
module tb_fdiv_recip_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errs;

    fdiv_recip_seq_if bus ();

    fdiv_recip_seq #(.ITERS(2), .SEED_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Integers r with |r - frac(2/(1.m))*2^23| <= 1, clipped to the 23-bit field.
    function automatic void ref_bounds(input logic [22:0] m, output longint lo, output longint hi);
        longint num;
        longint den;
        longint q;
        longint rem;
        num = longint'(1) << 47;
        den = (longint'(1) << 23) + longint'(m);
        q   = num / den;
        rem = num % den;
        lo  = q - (longint'(1) << 23) - ((rem == 0) ? 1 : 0);
        hi  = q - (longint'(1) << 23) + 1;
        if (lo < 0) lo = 0;
        if (hi > 64'h7FFFFF) hi = 64'h7FFFFF;
    endfunction

    task automatic run_op(input logic [31:0] xi, input bit hold_in, input bit pulse,
                          output logic [31:0] yo, output int lat);
        int n;
        @(negedge clk);
        bus.x         = xi;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 64'(n), 0);
        @(posedge clk);
        #1;
        bus.in_valid  = hold_in;
        bus.out_ready = pulse;
        if (hold_in) bus.x = $urandom;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        yo = bus.y;
        bus.in_valid = 1'b0;
        check("busy_in_ready", 64'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_recip(input string name, input logic [31:0] xi, input logic [31:0] yo);
        longint lo;
        longint hi;
        longint r;
        ref_bounds(xi[22:0], lo, hi);
        r = longint'(yo[22:0]);
        check($sformatf("%s_se", name), 64'(yo[31:23]), 64'(xi[31:23]));
        check($sformatf("%s_r m=%h r=%h lo=%h hi=%h", name, xi[22:0], yo[22:0], lo, hi),
              64'((r >= lo) && (r <= hi)), 1);
    endtask

    initial begin
        logic [31:0] yo;
        logic [31:0] xi;
        logic [31:0] y_hold;
        int          lat;
        int          bad;
        logic [31:0] dir [6];

        n_checks      = 0;
        n_errs        = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        #2;
        rst = 1'b1;
        #3;
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_y", 64'(bus.y), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed values: 1.5, -1.25, exact 2.0 and mantissa extremes.
        run_op(32'h3FC00000, 1'b0, 1'b0, yo, lat);
        check("x1p5_lat", 64'(lat), 6);
        check("x1p5_y_lo", 64'(yo >= 32'h3FAAAAA9 && yo <= 32'h3FAAAAAB), 1);
        check_recip("x1p5", 32'h3FC00000, yo);

        run_op(32'hBFA00000, 1'b0, 1'b0, yo, lat);
        check("xm1p25_s", 64'(yo[31]), 1);
        check("xm1p25_e", 64'(yo[30:23]), 8'h7F);
        check("xm1p25_r", 64'(yo[22:0] == 23'h4CCCCC || yo[22:0] == 23'h4CCCCD), 1);

        run_op(32'h40000000, 1'b0, 1'b0, yo, lat);
        check("m0_y", 64'(yo), 64'h407FFFFF);

        run_op(32'h3FFFFFFF, 1'b0, 1'b0, yo, lat);
        check("mmax_r", 64'(yo[22:0] <= 23'd1), 1);
        check("mmax_se", 64'(yo[31:23]), 9'h07F);

        run_op(32'h00400000, 1'b0, 1'b0, yo, lat);
        check("e0_y", 64'(yo), 64'h00000000);
        check("e0_lat", 64'(lat), 6);

        run_op(32'hFFC00000, 1'b0, 1'b0, yo, lat);
        check("e255_y", 64'(yo), 64'hFF800000);
        check("e255_lat", 64'(lat), 6);

        dir = '{32'h3F800001, 32'h3FFFFFFE, 32'h3F808000, 32'h3FFF8000, 32'h00000001, 32'h7F7FFFFF};
        foreach (dir[i]) begin
            run_op(dir[i], 1'b1, 1'b1, yo, lat);
            if (dir[i][30:23] == 8'h00) check("dir_e0", 64'(yo), 64'(dir[i] & 32'h80000000));
            else                        check_recip("dir", dir[i], yo);
        end

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        bus.x        = 32'h3FC00000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 64'(lat), 6);
        y_hold = bus.y;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.y !== y_hold || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        check("bp_stable_cycles_bad", 64'(bad), 0);
        check("bp_y", 64'(bus.y), 64'(y_hold));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", 64'(bus.in_ready), 1);
        check("bp_release_out_valid", 64'(bus.out_valid), 0);

        // Reset while the second multiply phase is in flight.
        @(negedge clk);
        bus.x        = 32'h3FC00000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 1);
        check("midrst_out_valid", 64'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) bad++;
        end
        check("midrst_no_output", 64'(bad), 0);
        run_op(32'h3FC00000, 1'b0, 1'b0, yo, lat);
        check("postrst_lat", 64'(lat), 6);
        check_recip("postrst", 32'h3FC00000, yo);

        // Random sweep over mantissas, signs and normal exponents.
        for (int k = 0; k < 3000; k++) begin
            xi[22:0]  = 23'($urandom);
            xi[30:23] = 8'($urandom_range(1, 254));
            xi[31]    = 1'($urandom);
            run_op(xi, 1'($urandom), 1'($urandom), yo, lat);
            check("rand_lat", 64'(lat), 6);
            check_recip("rand", xi, yo);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
